// File: rtl/rr_encoder_pkg.sv
// Shared types and helpers for the registered round-robin / fixed-priority encoder.
package rr_encoder_pkg;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  // Request vector width for a given index width.
  function automatic int calc_n(input int out_width);
    return 1 << out_width;
  endfunction

endpackage

// File: rtl/rr_encoder_prio_pick.sv
// Combinational picker: highest set bit (fixed) or first set bit at/after ptr (round-robin).
module prio_pick
  import rr_encoder_pkg::*;
#(
  parameter int OUT_WIDTH = 3,
  localparam int N = calc_n(OUT_WIDTH)
) (
  input  logic [N-1:0]         vec,
  input  logic [OUT_WIDTH-1:0] ptr,
  input  logic                 rr,
  output logic [OUT_WIDTH-1:0] idx,
  output logic                 hit
);

  logic [OUT_WIDTH-1:0] pos;

  always_comb begin
    idx = '0;
    hit = 1'b0;
    pos = '0;
    if (rr) begin
      // Scan offsets downward so the smallest offset from ptr is the last to win.
      for (int i = N - 1; i >= 0; i--) begin
        pos = ptr + OUT_WIDTH'(i);
        if (vec[pos]) begin
          idx = pos;
          hit = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) begin
          idx = OUT_WIDTH'(i);
          hit = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rr_encoder.sv
// Registered multi-hot to index encoder with valid/ready on both sides and optional drain.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid never depends on ready.
module rr_encoder
  import rr_encoder_pkg::*;
#(
  parameter int OUT_WIDTH = 3,
  localparam int N = calc_n(OUT_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rr_en,
  input  logic                 drain_en,
  input  logic [N-1:0]         req,
  input  logic                 req_valid,
  output logic                 req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_idx,
  output logic                 out_hit,
  output logic                 out_last
);

  state_e               state_q, state_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_idx_q, out_idx_d;
  logic                 out_hit_q, out_hit_d;
  logic                 out_last_q, out_last_d;
  logic [OUT_WIDTH-1:0] ptr_q, ptr_d;
  logic [N-1:0]         pending_q, pending_d;
  logic                 rr_q, rr_d;
  logic                 drain_q, drain_d;

  logic                 accept;
  logic                 out_hs;
  logic [N-1:0]         pick_vec;
  logic                 pick_rr;
  logic [OUT_WIDTH-1:0] pick_idx;
  logic                 pick_hit;
  logic [N-1:0]         pick_oh;
  logic [N-1:0]         pick_rest;

  assign req_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = req_valid && req_ready;
  assign out_hs    = out_valid_q && out_ready;

  // Accept can only happen in IDLE, so the picker sees the new vector then and pending otherwise.
  assign pick_vec = accept ? req : pending_q;
  assign pick_rr  = accept ? rr_en : rr_q;

  prio_pick #(.OUT_WIDTH(OUT_WIDTH)) u_pick (
    .vec (pick_vec),
    .ptr (ptr_q),
    .rr  (pick_rr),
    .idx (pick_idx),
    .hit (pick_hit)
  );

  always_comb begin
    pick_oh           = '0;
    pick_oh[pick_idx] = 1'b1;
    pick_rest         = pick_vec & ~pick_oh;
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_hit_d   = out_hit_q;
    out_last_d  = out_last_q;
    ptr_d       = ptr_q;
    pending_d   = pending_q;
    rr_d        = rr_q;
    drain_d     = drain_q;

    if (accept) begin
      rr_d        = rr_en;
      drain_d     = drain_en;
      out_valid_d = 1'b1;
      out_idx_d   = pick_idx;
      out_hit_d   = pick_hit;
      pending_d   = drain_en ? pick_rest : '0;
      out_last_d  = (pending_d == '0);
      state_d     = (pending_d != '0) ? S_BUSY : S_IDLE;
      if (pick_hit && rr_en) ptr_d = pick_idx + OUT_WIDTH'(1);
    end else if (out_hs) begin
      if (state_q == S_BUSY) begin
        out_idx_d  = pick_idx;
        out_hit_d  = pick_hit;
        pending_d  = pick_rest;
        out_last_d = (pending_d == '0);
        state_d    = (pending_d != '0) ? S_BUSY : S_IDLE;
        if (pick_hit && rr_q) ptr_d = pick_idx + OUT_WIDTH'(1);
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_hit_q   <= 1'b0;
      out_last_q  <= 1'b0;
      ptr_q       <= '0;
      pending_q   <= '0;
      rr_q        <= 1'b0;
      drain_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_hit_q   <= out_hit_d;
      out_last_q  <= out_last_d;
      ptr_q       <= ptr_d;
      pending_q   <= pending_d;
      rr_q        <= rr_d;
      drain_q     <= drain_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_hit   = out_hit_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_rr_encoder.sv
// Directed bench for rr_encoder (OUT_WIDTH = 3) with an expected-beat queue checked on each output handshake.
module tb_rr_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rr_en = 1'b0;
  logic       drain_en = 1'b0;
  logic [7:0] req = '0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [2:0] out_idx;
  logic       out_hit;
  logic       out_last;

  int tests = 0;
  int fails = 0;
  int wait_n;

  // Each entry is {idx, hit, last}.
  logic [4:0] exp_q[$];

  rr_encoder #(.OUT_WIDTH(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .rr_en     (rr_en),
    .drain_en  (drain_en),
    .req       (req),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_hit   (out_hit),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Scoreboard: a beat is consumed on the next rising edge when valid && ready at the falling edge.
  always @(negedge clk) begin
    logic [4:0] e;
    if (!rst && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $error("FAIL unexpected_beat: observed idx=%0d hit=%0d last=%0d, required no beat",
               out_idx, out_hit, out_last);
      end else begin
        e = exp_q.pop_front();
        assert ({out_idx, out_hit, out_last} === e) else begin
          fails++;
          $error("FAIL beat: observed idx=%0d hit=%0d last=%0d, required idx=%0d hit=%0d last=%0d",
                 out_idx, out_hit, out_last, e[4:2], e[1], e[0]);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic [2:0] idx, input logic hit, input logic last);
    exp_q.push_back({idx, hit, last});
  endfunction

  // Drive a vector just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] r, input logic rr, input logic dr, output int n);
    n = 0;
    req       = r;
    rr_en     = rr;
    drain_en  = dr;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", (n < 100), 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain_wait();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", (n < 100), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values, checked while reset is held and after release.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_hit", out_hit, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_req_ready", req_ready, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_req_ready", req_ready, 1);

    // Fixed, no drain: single beat one cycle after accept.
    push(3'd5, 1'b1, 1'b1);
    send(8'h26, 1'b0, 1'b0, wait_n);
    chk("fixed_latency_valid", out_valid, 1);
    chk("fixed_latency_idx", out_idx, 5);
    drain_wait();
    chk("fixed_ptr", dut.ptr_q, 0);
    chk("idle_valid_cleared", out_valid, 0);

    // Fixed drain 5,2,1 then a back-to-back vector on the final handshake edge.
    push(3'd5, 1'b1, 1'b0);
    push(3'd2, 1'b1, 1'b0);
    push(3'd1, 1'b1, 1'b1);
    send(8'h26, 1'b0, 1'b1, wait_n);
    chk("drain_first_wait", wait_n, 0);
    push(3'd4, 1'b1, 1'b1);
    send(8'h10, 1'b0, 1'b0, wait_n);
    chk("drain_busy_cycles", wait_n, 2);
    chk("back_to_back_valid", out_valid, 1);
    chk("back_to_back_idx", out_idx, 4);
    drain_wait();

    // Zero vector in both modes.
    push(3'd0, 1'b0, 1'b1);
    send(8'h00, 1'b0, 1'b0, wait_n);
    push(3'd0, 1'b0, 1'b1);
    send(8'h00, 1'b1, 1'b1, wait_n);
    drain_wait();
    chk("zero_ptr", dut.ptr_q, 0);

    // Round-robin, no drain, 8'h81 three times.
    push(3'd0, 1'b1, 1'b1);
    send(8'h81, 1'b1, 1'b0, wait_n);
    drain_wait();
    chk("rr_ptr_1", dut.ptr_q, 1);
    push(3'd7, 1'b1, 1'b1);
    send(8'h81, 1'b1, 1'b0, wait_n);
    drain_wait();
    chk("rr_ptr_wrap", dut.ptr_q, 0);
    push(3'd0, 1'b1, 1'b1);
    send(8'h81, 1'b1, 1'b0, wait_n);
    drain_wait();
    chk("rr_ptr_again", dut.ptr_q, 1);

    // Move ptr to 3, then round-robin drain of 8'h8B under backpressure.
    push(3'd2, 1'b1, 1'b1);
    send(8'h04, 1'b1, 1'b0, wait_n);
    drain_wait();
    chk("rr_ptr_3", dut.ptr_q, 3);
    push(3'd3, 1'b1, 1'b0);
    push(3'd7, 1'b1, 1'b0);
    push(3'd0, 1'b1, 1'b0);
    push(3'd1, 1'b1, 1'b1);
    send(8'h8B, 1'b1, 1'b1, wait_n);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_idx", out_idx, 3);
      chk("bp_req_ready", req_ready, 0);
    end
    chk("bp_queue_held", exp_q.size(), 4);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain_wait();
    chk("rr_drain_ptr", dut.ptr_q, 2);

    // Reset during the second beat of a fixed drain.
    push(3'd5, 1'b1, 1'b0);
    push(3'd2, 1'b1, 1'b0);
    push(3'd1, 1'b1, 1'b1);
    send(8'h26, 1'b0, 1'b1, wait_n);
    @(posedge clk);
    #1;
    chk("mid_drain_idx", out_idx, 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_idx", out_idx, 0);
    chk("mid_rst_hit", out_hit, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_ptr", dut.ptr_q, 0);
    chk("mid_rst_queue", exp_q.size(), 2);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    push(3'd0, 1'b1, 1'b1);
    send(8'h01, 1'b1, 1'b0, wait_n);
    drain_wait();
    chk("post_rst_rr_ptr", dut.ptr_q, 1);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_encoder.md
# rr_encoder

Parametrised, registered successor to the combinational `Encoder`. It accepts a multi-hot request vector over a valid/ready handshake and returns the index of the selected set bit. Selection is either fixed-priority (highest index wins) or round-robin with a persistent pointer. In drain mode it serialises every set bit of the vector, one index per output beat. It sits between request sources (interrupt lines, FIFO non-empty flags) and any consumer that needs a binary index stream.

## Interface
- `OUT_WIDTH`, default 3: index width; request width `N = 1 << OUT_WIDTH`.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `rr_en`  in  1  1 = round-robin selection, 0 = fixed priority. Sampled at request acceptance.
- `drain_en`  in  1  1 = emit every set bit, 0 = emit one index per vector. Sampled at acceptance.
- `req`  in  N  request vector.
- `req_valid`  in  1  `req` is valid.
- `req_ready`  out  1  block can accept a vector.
- `out_valid`  out  1  output beat is valid.
- `out_ready`  in  1  consumer accepts the beat.
- `out_idx`  out  OUT_WIDTH  selected index.
- `out_hit`  out  1  1 if the vector had at least one set bit.
- `out_last`  out  1  final beat for this vector.

## Operation
- States: IDLE (no pending bits) and BUSY (drain with bits remaining).
- `req_ready = (state == IDLE) && (!out_valid || out_ready)`. Combinational from registers and `out_ready`.
- Accept when `req_valid && req_ready`. Latch `rr_en` and `drain_en` for the whole vector.
- Pick function, given vector `v` and pointer `ptr`:
  - Fixed: highest set index.
  - Round-robin: first set index scanning upward from `ptr`, wrapping N-1 → 0.
  - `v == 0`: `idx = 0`, `hit = 0`.
- On accept:
  - Output register ← pick(`req`).
  - `pending` ← `req & ~onehot(idx)` if drain, else 0.
  - `out_last` ← (`pending == 0`).
  - Next state is BUSY if `pending != 0`, else IDLE.
- On output handshake in BUSY: output register ← pick(`pending`) and clear that bit from `pending`. `out_last` is set when the new `pending` is 0. Go to IDLE when `pending` becomes 0.
- On output handshake in IDLE with no accept in the same cycle: `out_valid` ← 0.
- Pointer (`ptr`, OUT_WIDTH bits, reset 0): whenever a beat with `hit = 1` and latched `rr = 1` is loaded into the output register, `ptr ← idx + 1`, modulo N by natural wrap. Fixed-mode beats leave `ptr` unchanged.
- Drain order: fixed mode gives descending indices; round-robin gives ascending indices, wrapping from `ptr`.
- A zero vector produces exactly one beat: `hit = 0`, `idx = 0`, `last = 1`.

## Timing
- Reset values: `out_valid = 0`, `out_idx = 0`, `out_hit = 0`, `out_last = 0`, `ptr = 0`, `pending = 0`, state IDLE. `req_ready` therefore reads 1 out of reset.
- Latency: accept at edge k, first beat has `out_valid = 1` after edge k.
- Throughput: one beat per cycle when `out_ready` is held high. A new vector is accepted on the same edge as the final beat's handshake, so there are no bubbles.
- Backpressure: while `out_valid && !out_ready`, `out_idx`, `out_hit`, `out_last`, `ptr` and `pending` hold. `req_ready` is 0.
- `req` and mode changes while `req_ready = 0` are ignored.
- Reset asserted mid-drain: all registers return to reset values immediately and the remaining bits are discarded.

## Structure
- Package `rr_encoder_pkg`: state enum (`S_IDLE`, `S_BUSY`) and a helper for the localparam `N = 1 << OUT_WIDTH`.
- Sub-module `prio_pick`: combinational, parametrised by OUT_WIDTH.
  - Inputs: `vec[N]`, `ptr`, `rr`.
  - Outputs: `idx`, `hit`.
  - Instantiated once. Its input mux selects between `req` at accept and `pending` in BUSY.

## Test plan
All scenarios use `OUT_WIDTH = 3`.
- Fixed, no drain, `req = 8'h26`, `out_ready = 1` → one beat: `idx = 5`, `hit = 1`, `last = 1`, one cycle after accept. `ptr` stays 0.
- Fixed, drain, `req = 8'h26` → beats `idx` 5, 2, 1 on consecutive cycles, `last` only on idx 1. `req_ready = 0` for 2 cycles. A second vector is accepted on the final handshake edge.
- Zero vector, either mode → single beat: `hit = 0`, `idx = 0`, `last = 1`.
- Round-robin, no drain, `req = 8'h81` sent three times → `idx` 0, 7, 0. `ptr` goes 1, 0 (wrap), 1.
- Round-robin, drain, `ptr = 3`, `req = 8'h8B` (bits 0, 1, 3, 7) → beats 3, 7, 0, 1. `out_ready` is held low for 3 cycles after the first beat; `idx = 3` stays stable and no beat is lost or duplicated.
- `rst` pulsed during the second beat of a drain → outputs zero and `req_ready = 1` while reset is asserted. After release, a new `req = 8'h01` in round-robin yields `idx = 0` (`ptr` was reset).
